int_fp_div: RTL and testbench
=============================

# int_fp_div

Iterative dual-mode divider, the inverse-operation companion to the dual-mode int/fp16 multiplier in the systolic processing element. Computes a/b either as a signed integer divide or as an fp16 divide with a radix-2 restoring datapath. Uses a start/busy/done handshake with fixed, mode-dependent latency and the same saturate-and-flag error convention as the multiplier.

## Interface
- No parameters.
- clk  in  1  clock; reset rst_n, asynchronous, active-low.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only while busy=0.
- mode  in  1  1 = fp16, 0 = integer; latched with start.
- a  in  16  dividend: fp16, or signed 16-bit integer.
- b  in  16  divisor: fp16, or signed 8-bit integer in b[7:0] (b[15:8] ignored).
- c  out  16  result; held from done until next accepted start.
- error  out  1  divide-by-zero, overflow or underflow; valid with c.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse, c/error valid.

## Operation
- FSM: IDLE -> PREP -> DIV (N cycles) -> POST -> IDLE. N=16 in int mode, N=11 in fp mode.
- IDLE: start=1 latches mode, a, b; go to PREP. start while busy is ignored; operands are not re-sampled.
- Int PREP: magnitudes |a| (17-bit safe) and |b[7:0]|; quotient sign = a[15]^b[7].
- Int DIV: 16 restoring steps, one quotient bit per cycle, MSB first.
- Int POST: negate if sign set; truncate toward zero.
- Int b[7:0]=0: c=0x7FFF if a[15]=0, else 0x8000; error=1.
- Int a=0x8000 with b[7:0]=0xFF: c=0x7FFF, error=1.
- FP zero test uses bits [14:0] only, so -0 counts as zero. Exponent 31 is treated as an ordinary exponent; there is no inf/NaN input handling.
- FP PREP: ma={1,a[9:0]}, mb={1,b[9:0]}, e=a[14:10]-b[14:10]+15 (7-bit signed).
- FP PREP: if ma<mb, ma<<=1 and e-=1. sign=a[15]^b[15].
- FP DIV: 11 restoring steps give q in [1,2) as 1.f[9:0]; truncate, no rounding.
- FP POST, checked in this priority:
  - a and b both zero: c=0x7E00, error=1.
  - b zero: c={sign,0x1F,10'b0}, error=1.
  - a zero: c=0x0000, error=0.
  - e>=31: c={sign,0x1F,10'b0}, error=1.
  - e<=0: c={sign,15'b0}, error=1.
  - Otherwise: c={sign,e[4:0],q[9:0]}, error=0.
- Special cases still run the full latency, so latency is fixed per mode.

## Timing
- Reset values: c=0, error=0, busy=0, done=0; FSM=IDLE; iteration counter=0.
- Reset asserted mid-operation aborts the operation; no done is produced.
- start sampled high at edge T: busy=1 after T, through edge T+N+1.
- After edge T+N+2: done=1, busy=0, c/error updated. That is T+18 in int mode, T+13 in fp mode.
- done lasts exactly one cycle.
- A start sampled on the edge that ends the done cycle is accepted, giving back-to-back throughput of one result per N+2 cycles.
- c/error are stable between done pulses; they are not cleared at start.

## Test plan
- fp: a=0x4200, b=0x4000, start at T -> done at T+13, c=0x3E00, error=0, busy high T+1..T+12.
- fp normalize: a=0x3C00, b=0x4200 -> c=0x3555, error=0.
- fp errors:
  - a=0x7BFF, b=0x1400 -> c=0x7C00, error=1.
  - a=0xC000, b=0x0000 -> c=0xFC00, error=1.
  - a=0, b=0 -> c=0x7E00, error=1.
- int: a=0xFF9C, b=0x0007 -> done at T+18, c=0xFFF2, error=0.
- int errors:
  - a=0x8000, b=0x00FF -> c=0x7FFF, error=1.
  - a=0x0005, b=0x0000 -> c=0x7FFF, error=1.
- Handshake/reset:
  - start pulsed again while busy -> ignored, first result unchanged.
  - start held high through done -> second op accepted back-to-back.
  - rst_n low mid-DIV -> all outputs 0, no done; a fresh start completes normally.

Source files
------------

// File: rtl/int_fp_div_if.sv
// Handshake and operand bundle for int_fp_div.
//   start  request, sampled only while busy is low
//   mode   1 = fp16 divide, 0 = signed integer divide
//   a      dividend (fp16 or signed 16-bit integer)
//   b      divisor (fp16, or signed 8-bit integer in b[7:0])
//   c      result, held from done until the next accepted start
//   error  divide-by-zero / overflow / underflow flag, valid with c
//   busy   operation in progress
//   done   one-cycle pulse marking c/error valid
interface int_fp_div_if;
   logic        start;
   logic        mode;
   logic [15:0] a;
   logic [15:0] b;
   logic [15:0] c;
   logic        error;
   logic        busy;
   logic        done;

   modport master (
      output start, mode, a, b,
      input  c, error, busy, done
   );

   modport slave (
      input  start, mode, a, b,
      output c, error, busy, done
   );
endinterface

// File: rtl/int_fp_div.sv
// Iterative dual-mode divider: a/b as a signed integer divide (16-bit
// dividend, 8-bit divisor) or as an fp16 divide, using one radix-2
// restoring step per cycle. The latency is fixed per mode: done pulses
// N+2 cycles after start is accepted, where N=16 (int) or N=11 (fp).
// Special cases saturate the result and raise error.
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    int_fp_div_if slave: start/mode/a/b in, c/error/busy/done out
module int_fp_div (
   input  logic        clk,
   input  logic        rst_n,
   int_fp_div_if.slave bus
);

   typedef enum logic [1:0] {IDLE, PREP, DIV, POST} state_t;

   state_t             state;
   logic               mode_r;
   logic [15:0]        a_r;
   logic [15:0]        b_r;
   logic [16:0]        rem;
   logic [15:0]        quo;
   logic [10:0]        dvs;
   logic [3:0]         cnt;
   logic               sign;
   logic signed [6:0]  exp_r;
   logic [15:0]        c_r;
   logic               err_r;
   logic               busy_r;
   logic               done_r;

   // Operand preparation, from the latched operands.
   logic [15:0]        a_mag;
   logic [7:0]         b_mag;
   logic [10:0]        ma;
   logic [10:0]        mb;
   logic signed [6:0]  exp_raw;

   // Sign-magnitude of 0x8000 is 0x8000 read as unsigned, so 16 bits suffice.
   assign a_mag   = a_r[15] ? (~a_r + 16'd1) : a_r;
   assign b_mag   = b_r[7] ? (~b_r[7:0] + 8'd1) : b_r[7:0];
   assign ma      = {1'b1, a_r[9:0]};
   assign mb      = {1'b1, b_r[9:0]};
   assign exp_raw = $signed({2'b00, a_r[14:10]}) - $signed({2'b00, b_r[14:10]}) + 7'sd15;

   // One restoring step. Int mode shifts the next dividend bit into the
   // partial remainder before the trial subtract; fp mode starts with the
   // whole mantissa in rem and doubles the remainder after the subtract.
   logic [16:0] trial;
   logic [16:0] rem_next;
   logic [15:0] quo_next;
   logic        fits;

   // NOTE: every combinational output gets a value on every path, so no latch is inferred.
   always_comb begin
      trial    = mode_r ? rem : {rem[15:0], quo[15]};
      fits     = trial >= {6'd0, dvs};
      rem_next = fits ? (trial - {6'd0, dvs}) : trial;
      if (mode_r)
         rem_next = {rem_next[15:0], 1'b0};
      quo_next = {quo[14:0], fits};
   end

   // Final result selection, evaluated in POST.
   logic        a_zero;
   logic        b_zero;
   logic [15:0] res_c;
   logic        res_err;

   // fp zero ignores the sign bit, so -0 is zero too.
   assign a_zero = (a_r[14:0] == 15'd0);
   assign b_zero = (b_r[14:0] == 15'd0);

   always_comb begin
      res_c   = 16'h0000;
      res_err = 1'b0;
      if (mode_r) begin
         if (a_zero && b_zero) begin
            res_c   = 16'h7E00;
            res_err = 1'b1;
         end else if (b_zero) begin
            res_c   = {sign, 5'h1F, 10'h000};
            res_err = 1'b1;
         end else if (a_zero) begin
            res_c   = 16'h0000;
            res_err = 1'b0;
         end else if (exp_r >= 7'sd31) begin
            res_c   = {sign, 5'h1F, 10'h000};
            res_err = 1'b1;
         end else if (exp_r <= 7'sd0) begin
            res_c   = {sign, 15'h0000};
            res_err = 1'b1;
         end else begin
            // quo[10] is the implicit leading one of q in [1,2).
            res_c   = {sign, exp_r[4:0], quo[9:0]};
            res_err = 1'b0;
         end
      end else begin
         if (b_r[7:0] == 8'h00) begin
            res_c   = a_r[15] ? 16'h8000 : 16'h7FFF;
            res_err = 1'b1;
         end else if (a_r == 16'h8000 && b_r[7:0] == 8'hFF) begin
            res_c   = 16'h7FFF;
            res_err = 1'b1;
         end else begin
            res_c   = sign ? (~quo + 16'd1) : quo;
            res_err = 1'b0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mode_r <= 1'b0;
         a_r    <= '0;
         b_r    <= '0;
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         cnt    <= '0;
         sign   <= 1'b0;
         exp_r  <= '0;
         c_r    <= '0;
         err_r  <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  mode_r <= bus.mode;
                  a_r    <= bus.a;
                  b_r    <= bus.b;
                  busy_r <= 1'b1;
                  state  <= PREP;
               end
            end
            PREP: begin
               if (mode_r) begin
                  sign <= a_r[15] ^ b_r[15];
                  dvs  <= mb;
                  quo  <= '0;
                  // Pre-normalise so the quotient lands in [1,2).
                  if (ma < mb) begin
                     rem   <= {5'd0, ma, 1'b0};
                     exp_r <= exp_raw - 7'sd1;
                  end else begin
                     rem   <= {6'd0, ma};
                     exp_r <= exp_raw;
                  end
                  cnt <= 4'd10;
               end else begin
                  sign  <= a_r[15] ^ b_r[7];
                  dvs   <= {3'd0, b_mag};
                  rem   <= '0;
                  quo   <= a_mag;
                  exp_r <= '0;
                  cnt   <= 4'd15;
               end
               state <= DIV;
            end
            DIV: begin
               rem <= rem_next;
               quo <= quo_next;
               if (cnt == 4'd0)
                  state <= POST;
               else
                  cnt <= cnt - 4'd1;
            end
            POST: begin
               c_r    <= res_c;
               err_r  <= res_err;
               done_r <= 1'b1;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.c     = c_r;
   assign bus.error = err_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;

endmodule

// File: tb/tb_int_fp_div.sv
// Scoreboard bench for int_fp_div: each issued operation pushes its
// hand-computed result and expected done cycle; a monitor pops and
// compares whenever done is seen.
module tb_int_fp_div;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   int_fp_div_if bus ();

   int_fp_div dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      logic [15:0] c;
      logic        err;
      int          done_cyc;
      string       name;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitor: compare every done against the head of the scoreboard.
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.done) begin
         check("done_one_cycle", {31'd0, prev_done}, 32'd0);
         if (sb.size() == 0) begin
            check("spurious_done", {31'd0, bus.done}, 32'd0);
         end else begin
            e = sb.pop_front();
            check({e.name, "_c"}, {16'd0, bus.c}, {16'd0, e.c});
            check({e.name, "_err"}, {31'd0, bus.error}, {31'd0, e.err});
            check({e.name, "_lat"}, cyc, e.done_cyc);
            check({e.name, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
         end
      end
      prev_done = rst_n & bus.done;
   end

   function automatic int lat(input logic m);
      return m ? 13 : 18;
   endfunction

   // Drive one start pulse; returns at the negedge after the accepting edge T.
   task automatic issue(input logic m, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] ec, input logic ee, input string nm, input bit push);
      exp_t e;
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = m;
      bus.a     = av;
      bus.b     = bv;
      if (push) begin
         e.c = ec; e.err = ee; e.done_cyc = cyc + 1 + lat(m); e.name = nm;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         check("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic        m;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
      logic        err;
      string       name;
   } vec_t;

   vec_t vecs[] = '{
      '{1'b1, 16'h3C00, 16'h4200, 16'h3555, 1'b0, "fp_norm"},
      '{1'b1, 16'h7BFF, 16'h1400, 16'h7C00, 1'b1, "fp_ovf"},
      '{1'b1, 16'hC000, 16'h0000, 16'hFC00, 1'b1, "fp_bzero"},
      '{1'b1, 16'h0000, 16'h0000, 16'h7E00, 1'b1, "fp_zz"},
      '{1'b1, 16'h8000, 16'h4000, 16'h0000, 1'b0, "fp_azero"},
      '{1'b1, 16'h0400, 16'h7800, 16'h8000 ^ 16'h8000, 1'b1, "fp_unf"},
      '{1'b0, 16'hFF9C, 16'h0007, 16'hFFF2, 1'b0, "int_neg"},
      '{1'b0, 16'hFF9C, 16'h00F9, 16'h000E, 1'b0, "int_negneg"},
      '{1'b0, 16'h8000, 16'h00FF, 16'h7FFF, 1'b1, "int_ovf"},
      '{1'b0, 16'h0005, 16'h0000, 16'h7FFF, 1'b1, "int_bzero"},
      '{1'b0, 16'h8001, 16'hAB00, 16'h8000, 1'b1, "int_negbzero"},
      '{1'b0, 16'h8000, 16'h0001, 16'h8000, 1'b0, "int_min_by_1"},
      '{1'b0, 16'h7FFF, 16'h0080, 16'hFF01, 1'b0, "int_by_m128"}
   };

   initial begin
      int busy_n;
      exp_t e;
      bus.start = 1'b0;
      bus.mode  = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_c", {16'd0, bus.c}, 32'd0);
      check("rst_err", {31'd0, bus.error}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // First fp op with busy window: high for N+2 = 13 samples before done.
      issue(1'b1, 16'h4200, 16'h4000, 16'h3E00, 1'b0, "fp_basic", 1'b1);
      busy_n = 0;
      for (int i = 0; i < 40 && !bus.done; i++) begin
         if (bus.busy) busy_n++;
         @(negedge clk);
      end
      check("fp_busy_cycles", busy_n, 13);
      drain(40);

      foreach (vecs[i]) begin
         issue(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].err, vecs[i].name, 1'b1);
         drain(40);
      end

      // Start pulsed while busy is ignored; operands not re-sampled.
      issue(1'b0, 16'hFF9C, 16'h0007, 16'hFFF2, 1'b0, "busy_ignore", 1'b1);
      repeat (3) @(negedge clk);
      bus.start = 1'b1; bus.mode = 1'b1; bus.a = 16'h4200; bus.b = 16'h4000;
      @(negedge clk);
      bus.start = 1'b0;
      drain(40);
      repeat (25) @(negedge clk);
      check("busy_ignore_hold_c", {16'd0, bus.c}, 32'h0000FFF2);
      check("busy_ignore_idle", {31'd0, bus.busy}, 32'd0);

      // Start held high through done: second op accepted back-to-back.
      @(negedge clk);
      bus.start = 1'b1; bus.mode = 1'b1; bus.a = 16'h4200; bus.b = 16'h4000;
      e.c = 16'h3E00; e.err = 1'b0; e.done_cyc = cyc + 1 + 13; e.name = "b2b_first";
      sb.push_back(e);
      e.c = 16'hFFF2; e.err = 1'b0; e.done_cyc = cyc + 1 + 13 + 1 + 18; e.name = "b2b_second";
      sb.push_back(e);
      for (int i = 0; i < 40 && !bus.done; i++) @(negedge clk);
      bus.mode = 1'b0; bus.a = 16'hFF9C; bus.b = 16'h0007;
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b_busy_after_accept", {31'd0, bus.busy}, 32'd1);
      drain(60);

      // Reset mid-DIV aborts with no done; a fresh start then completes.
      issue(1'b0, 16'h0064, 16'h0007, 16'h000E, 1'b0, "aborted", 1'b0);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_c", {16'd0, bus.c}, 32'd0);
      check("abort_err", {31'd0, bus.error}, 32'd0);
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_done", {31'd0, bus.done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      check("abort_c_hold", {16'd0, bus.c}, 32'd0);
      issue(1'b1, 16'h4200, 16'h4000, 16'h3E00, 1'b0, "after_reset", 1'b1);
      drain(40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
